// File: rtl/dual_port_ram_param_if.sv
// Request/response bundle for dual_port_ram_param: write port, read port,
// clear request and status. The RAM takes the slave side.
interface dual_port_ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     addr_wr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     addr_rd;
    logic [DATA_W-1:0]     data_out;
    logic                  rd_valid;
    logic                  clr;
    logic                  init_busy;

    modport master (
        output wr_en, addr_wr, data_in, be, rd_en, addr_rd, clr,
        input  data_out, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, addr_wr, data_in, be, rd_en, addr_rd, clr,
        output data_out, rd_valid, init_busy
    );
endinterface

// File: rtl/dual_port_ram_param.sv
// Simple dual-port RAM: byte-enable write port, pipelined read port with
// RD_LAT output stages, selectable collision result and a zeroing sequencer.
module dual_port_ram_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RD_LAT    = 1,
    parameter int COLL_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dual_port_ram_param_if.slave   bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]                    r_state;
    logic [ADDR_W-1:0]             r_clr_ptr;
    logic [DATA_W-1:0]             r_mem [DEPTH];
    logic [RD_LAT:1]               r_vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0]   r_dpipe;

    logic                          w_ready;
    logic                          w_wr_acc;
    logic                          w_rd_acc;
    logic [DATA_W-1:0]             w_rd_word;

    assign w_ready  = (r_state == S_READY);
    assign w_wr_acc = w_ready & bus.wr_en;
    assign w_rd_acc = w_ready & bus.rd_en;

    // clr has priority in both states so a request during CLEAR restarts at word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else if (bus.clr) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            if (r_clr_ptr == '1)
                r_state <= S_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (bus.wr_en) begin
            for (int k = 0; k < NB; k++)
                if (bus.be[k])
                    r_mem[bus.addr_wr][8*k +: 8] <= bus.data_in[8*k +: 8];
        end
    end

    // new-data collision mode forwards the enabled write bytes over the array word
    always_comb begin
        w_rd_word = r_mem[bus.addr_rd];
        if (COLL_MODE == 1 && w_wr_acc && bus.addr_wr == bus.addr_rd) begin
            for (int k = 0; k < NB; k++)
                if (bus.be[k])
                    w_rd_word[8*k +: 8] = bus.data_in[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_dpipe    <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_acc;
            if (w_rd_acc)
                r_dpipe[1] <= w_rd_word;
            for (int k = 2; k <= RD_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                if (r_vld_pipe[k-1])
                    r_dpipe[k] <= r_dpipe[k-1];
            end
        end
    end

    assign bus.data_out  = r_dpipe[RD_LAT];
    assign bus.rd_valid  = r_vld_pipe[RD_LAT];
    assign bus.init_busy = (r_state == S_CLEAR);
endmodule
